// File: rtl/apb4_multi_slave_master.sv
// apb4_multi_slave_master: valid/ready command port onto an APB4 bus
// with NUM_SLAVES completers, window decode, strobes and timeout.
module apb4_multi_slave_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int NUM_SLAVES = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
  parameter int SLAVE_ADDR_BITS = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_write,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [1:0]                       req_size,
  input  logic [2:0]                       req_prot,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  output logic [2:0]                       PPROT,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int LW = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

  state_t                  state, state_d;
  logic [IW-1:0]           idx, idx_d;
  logic [TW-1:0]           cnt, cnt_d;
  logic [ADDR_WIDTH-1:0]   paddr_d;
  logic [NUM_SLAVES-1:0]   psel_d;
  logic                    penable_d, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_d;
  logic [STRB_WIDTH-1:0]   pstrb_d;
  logic [2:0]              pprot_d;
  logic                    rv_d, rerr_d;
  logic [DATA_WIDTH-1:0]   rdata_d;

  logic [ADDR_WIDTH-1:0]   off, slot;
  logic                    hit, accept, tmo;
  logic [IW-1:0]           hit_idx;
  logic [STRB_WIDTH-1:0]   strb;
  logic                    sel_rdy, sel_err;
  logic [DATA_WIDTH-1:0]   sel_rd;
  int                      nb, lane;

  assign off     = req_addr - BASE_ADDR;
  assign slot    = off >> SLAVE_ADDR_BITS;
  assign hit     = (req_addr >= BASE_ADDR) &&
                   (slot < ADDR_WIDTH'(NUM_SLAVES));
  assign hit_idx = slot[IW-1:0];

  assign sel_rdy = PREADY[idx];
  assign sel_err = PSLVERR[idx];
  assign sel_rd  = PRDATA[idx*DATA_WIDTH +: DATA_WIDTH];

  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (cnt == TW'(TIMEOUT_CYCLES - 1));

  assign req_ready = PRESETn &&
                     ((state == IDLE) || (state == ACCESS && sel_rdy));
  assign accept = req_valid && req_ready;

  // Lane offset is aligned down to the access size; PADDR stays raw.
  always_comb begin
    nb   = 1 << req_size;
    lane = int'(req_addr[LW-1:0]) & ~(nb - 1);
    if (!req_write)
      strb = '0;
    else if (nb >= STRB_WIDTH)
      strb = '1;
    else
      strb = STRB_WIDTH'((1 << nb) - 1) << lane;
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    paddr_d   = PADDR;
    psel_d    = PSEL;
    penable_d = PENABLE;
    pwrite_d  = PWRITE;
    pwdata_d  = PWDATA;
    pstrb_d   = PSTRB;
    pprot_d   = PPROT;
    rv_d      = 1'b0;
    rerr_d    = 1'b0;
    rdata_d   = '0;
    unique case (state)
      IDLE: state_d = IDLE;
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (sel_rdy) begin
          rv_d      = 1'b1;
          rerr_d    = sel_err;
          rdata_d   = (PWRITE || sel_err) ? '0 : sel_rd;
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
        end else if (tmo) begin
          rv_d      = 1'b1;
          rerr_d    = 1'b1;
          state_d   = IDLE;
          psel_d    = '0;
          penable_d = 1'b0;
        end else begin
          cnt_d = cnt + TW'(1);
        end
      end
      DERR: begin
        rv_d    = 1'b1;
        rerr_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A command taken on a completing edge goes straight to SETUP.
    if (accept) begin
      penable_d = 1'b0;
      if (hit) begin
        state_d  = SETUP;
        idx_d    = hit_idx;
        psel_d   = NUM_SLAVES'(1) << hit_idx;
        paddr_d  = req_addr;
        pwrite_d = req_write;
        pwdata_d = req_wdata;
        pstrb_d  = strb;
        pprot_d  = req_prot;
      end else begin
        state_d = DERR;
        psel_d  = '0;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      PADDR     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      PPROT     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      cnt       <= cnt_d;
      PADDR     <= paddr_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      PSTRB     <= pstrb_d;
      PPROT     <= pprot_d;
      rsp_valid <= rv_d;
      rsp_err   <= rerr_d;
      rsp_rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_apb4_multi_slave_master.sv
// tb_apb4_multi_slave_master: transaction-timeline model with a
// per-cycle compare, directed plan cases and randomized traffic.
module tb_apb4_multi_slave_master;

  localparam int NS = 4;
  localparam int SW = 4;
  localparam int TO = 16;
  localparam longint unsigned BASE = 64'h4000_0000;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [1:0]   req_size = '0;
  logic [2:0]   req_prot = '0;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [31:0]  PADDR;
  logic [3:0]   PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [2:0]   PPROT;
  logic [3:0]   PREADY = '0;
  logic [127:0] PRDATA = '0;
  logic [3:0]   PSLVERR = '0;

  apb4_multi_slave_master dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_prot(req_prot), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PPROT(PPROT), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int a; bit hit; int idx; int n; bit tmo; int w;
    bit wr; bit err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] strb; logic [2:0] prot;
  } txn_t;
  typedef struct { int c; logic [3:0] psel, strb; logic [31:0] addr; } su_t;
  typedef struct { int c; bit err; logic [31:0] rd; } rs_t;

  txn_t q[$];
  su_t  su_log[$];
  rs_t  rs_log[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   pen_cnt = 0;
  int   acc_cyc = 0;
  bit   took = 0;
  int   cur_w = 0;
  logic [31:0] cur_rdata = '0;
  bit   cur_err = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic int rc(txn_t t);
    return t.hit ? t.a + 2 + t.n : t.a + 2;
  endfunction

  // Spec-level view of one accepted command.
  function automatic txn_t mk(int c);
    txn_t t;
    longint unsigned ad, nb, lane;
    ad = req_addr;
    t.a = c; t.wr = req_write; t.addr = req_addr;
    t.wdata = req_wdata; t.prot = req_prot;
    t.rdata = cur_rdata; t.err = cur_err; t.w = cur_w;
    t.hit = (ad >= BASE) && ((ad - BASE) / 4096 < NS);
    t.idx = t.hit ? int'((ad - BASE) / 4096) : 0;
    t.n = (cur_w + 1 < TO) ? cur_w + 1 : TO;
    t.tmo = (cur_w >= TO);
    nb = 1 << req_size;
    if (!req_write) t.strb = 4'h0;
    else if (nb >= SW) t.strb = 4'hF;
    else begin
      lane = (ad % SW) / nb * nb;
      t.strb = 4'(((1 << nb) - 1) << lane);
    end
    return t;
  endfunction

  initial begin : mon
    txn_t t, et;
    int c;
    logic [3:0] pr, ep;
    bit een, erv, eerr, erdy, have;
    logic [31:0] erd;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        q.delete();
        PREADY = '0;
      end else begin
        c = cyc;
        pr = 4'($urandom);
        PRDATA = {$urandom, $urandom, $urandom, $urandom};
        PSLVERR = 4'($urandom);
        foreach (q[i]) begin
          if (q[i].hit && c >= q[i].a + 2 && c <= q[i].a + 1 + q[i].n) begin
            pr[q[i].idx] = (c - (q[i].a + 2) == q[i].w);
            if (pr[q[i].idx]) begin
              PRDATA[q[i].idx*32 +: 32] = q[i].rdata;
              PSLVERR[q[i].idx] = q[i].err;
            end
          end
        end
        PREADY = pr;
        #1;
        ep = '0; een = 0; erv = 0; eerr = 0; erd = '0;
        erdy = 1; have = 0; et = '{default: 0};
        foreach (q[i]) begin
          t = q[i];
          if (t.hit && c >= t.a + 1 && c <= t.a + 1 + t.n) begin
            ep = 4'(1 << t.idx);
            een = (c >= t.a + 2);
            have = 1;
            et = t;
            if (!(c == t.a + 1 + t.n && !t.tmo)) erdy = 0;
          end
          if (!t.hit && c == t.a + 1) erdy = 0;
          if (c == rc(t)) begin
            erv = 1;
            eerr = !t.hit || t.tmo || t.err;
            erd = (t.hit && !t.tmo && !t.err && !t.wr) ? t.rdata : 32'h0;
          end
        end
        chk("PSEL", PSEL, ep);
        chk("PENABLE", PENABLE, een);
        chk("rsp_valid", rsp_valid, erv);
        chk("req_ready", req_ready, erdy);
        if (erv) begin
          chk("rsp_err", rsp_err, eerr);
          chk("rsp_rdata", rsp_rdata, erd);
        end
        if (have) begin
          chk("PADDR", PADDR, et.addr);
          chk("PWRITE", PWRITE, et.wr);
          chk("PSTRB", PSTRB, et.strb);
          chk("PPROT", PPROT, et.prot);
          if (et.wr) chk("PWDATA", PWDATA, et.wdata);
        end
        if (PENABLE) pen_cnt++;
        if (|PSEL && !PENABLE) su_log.push_back('{c, PSEL, PSTRB, PADDR});
        if (rsp_valid) rs_log.push_back('{c, rsp_err, rsp_rdata});
        if (req_valid && req_ready) begin
          q.push_back(mk(c));
          acc_cyc = c;
          took = 1;
        end
        while (q.size() > 0 && rc(q[0]) < c) void'(q.pop_front());
      end
    end
  end

  task automatic send(bit wr, logic [31:0] ad, logic [31:0] wd,
                      int sz, int w, logic [31:0] rd, bit er);
    int k;
    k = 0;
    req_valid = 1; req_write = wr; req_addr = ad; req_wdata = wd;
    req_size = 2'(sz); req_prot = 3'($urandom);
    cur_w = w; cur_rdata = rd; cur_err = er;
    took = 0;
    do begin @(posedge PCLK); k++; end while (!took && k < 200);
    chk("accepted", took, 1);
    #1;
    req_valid = 0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic wait_rsp(int n);
    int k;
    k = 0;
    do begin @(posedge PCLK); k++; end while (rs_log.size() < n && k < 100);
    #1;
    chk("rsp_count", rs_log.size(), n);
  endtask

  task automatic clr();
    su_log.delete(); rs_log.delete(); pen_cnt = 0;
  endtask

  initial begin
    logic [31:0] ad;
    int s, r;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    PRESETn = 1;
    @(negedge PCLK); #2;
    chk("rst_ready_after", req_ready, 1);
    @(posedge PCLK); #1;

    clr(); send(1, 32'h4000_2004, 32'hDEADBEEF, 2, 0, 0, 0); wait_rsp(1);
    chk("t1_psel", su_log[0].psel, 4'b0100);
    chk("t1_pstrb", su_log[0].strb, 4'b1111);
    chk("t1_pen_cycles", pen_cnt, 1);
    chk("t1_latency", rs_log[0].c - acc_cyc, 3);
    chk("t1_err", rs_log[0].err, 0);

    clr(); send(1, 32'h4000_1003, 32'hA5A5A5A5, 0, 0, 0, 0); wait_rsp(1);
    chk("t2_byte_pstrb", su_log[0].strb, 4'b1000);
    chk("t2_byte_paddr", su_log[0].addr, 32'h4000_1003);
    clr(); send(1, 32'h4000_1003, 32'h5A5A5A5A, 1, 0, 0, 0); wait_rsp(1);
    chk("t2_half_pstrb", su_log[0].strb, 4'b1100);
    chk("t2_half_paddr", su_log[0].addr, 32'h4000_1003);

    clr(); send(0, 32'h4000_3010, 0, 2, 5, 32'h1234_5678, 0); wait_rsp(1);
    chk("t3_pen_cycles", pen_cnt, 6);
    chk("t3_rdata", rs_log[0].rd, 32'h1234_5678);
    chk("t3_err", rs_log[0].err, 0);

    clr(); send(0, 32'h4000_4000, 0, 2, 0, 32'h1111_1111, 0); wait_rsp(1);
    chk("t4_miss_no_psel", su_log.size(), 0);
    chk("t4_miss_err", rs_log[0].err, 1);
    chk("t4_miss_rdata", rs_log[0].rd, 0);
    chk("t4_miss_latency", rs_log[0].c - acc_cyc, 2);

    clr(); send(0, 32'h4000_1000, 0, 2, 20, 32'h2222_2222, 0); wait_rsp(1);
    chk("t4_tmo_pen_cycles", pen_cnt, 16);
    chk("t4_tmo_err", rs_log[0].err, 1);
    chk("t4_tmo_rdata", rs_log[0].rd, 0);
    chk("t4_tmo_latency", rs_log[0].c - acc_cyc, 18);

    clr(); send(0, 32'h4000_1008, 0, 2, 15, 32'h3333_3333, 0); wait_rsp(1);
    chk("t4_edge_pen_cycles", pen_cnt, 16);
    chk("t4_edge_err", rs_log[0].err, 0);
    chk("t4_edge_rdata", rs_log[0].rd, 32'h3333_3333);

    clr();
    send(1, 32'h4000_0010, 32'h0000_0011, 2, 0, 0, 1);
    send(0, 32'h4000_3020, 0, 2, 0, 32'hCAFE_F00D, 0);
    wait_rsp(2);
    chk("t5_setup_gap", su_log[1].c - su_log[0].c, 2);
    chk("t5_err_first", rs_log[0].err, 1);
    chk("t5_err_second", rs_log[1].err, 0);
    chk("t5_rdata_second", rs_log[1].rd, 32'hCAFE_F00D);

    clr(); send(0, 32'h4000_0100, 0, 2, 8, 32'h5555_5555, 0);
    @(posedge PCLK); #3;
    PRESETn = 0;
    #1;
    chk("t6_psel", PSEL, 0);
    chk("t6_penable", PENABLE, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1;
    clr(); send(0, 32'h4000_2040, 0, 2, 1, 32'h0BAD_CAFE, 0); wait_rsp(1);
    chk("t6_after_rdata", rs_log[0].rd, 32'h0BAD_CAFE);
    chk("t6_after_err", rs_log[0].err, 0);
    chk("t6_after_latency", rs_log[0].c - acc_cyc, 4);

    for (int i = 0; i < 150; i++) begin
      s = $urandom_range(0, 9);
      if (s <= 5) ad = 32'(BASE + s * 4096 + $urandom_range(0, 4095));
      else if (s == 6) ad = 32'(BASE - 1 - $urandom_range(0, 4095));
      else if (s == 7) ad = 32'(BASE + NS * 4096 - 1);
      else if (s == 8) ad = 32'(BASE + NS * 4096);
      else ad = 32'(BASE);
      r = $urandom_range(0, 9);
      send(1'($urandom), ad, $urandom, $urandom_range(0, 2),
           (r < 6) ? r % 4 : 14 + (r - 6), $urandom,
           ($urandom_range(0, 5) == 0));
      r = $urandom_range(0, 2);
      if (r > 0) idle(r);
    end
    idle(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb4_multi_slave_master.md
Name: apb4_multi_slave_master

Overview:
Parametrised APB4 requester bridging a simple valid/ready command port to an APB4 bus with NUM_SLAVES completers.
- Decodes the address window into one-hot PSEL and muxes per-slave PREADY/PRDATA/PSLVERR.
- Generates size/alignment-based PSTRB and passes PPROT through.
- Reports decode errors, slave errors and wait-state timeouts, and supports back-to-back transfers without an IDLE bubble.
- Successor to the fixed two-slave APB master; sits between the core load/store unit and the peripheral fabric.

Parameters:
ADDR_WIDTH, 32, address bus width
DATA_WIDTH, 32, data bus width (32 or 64 only)
STRB_WIDTH, DATA_WIDTH/8, byte strobe width
NUM_SLAVES, 4, number of completers (1..16)
BASE_ADDR, 32'h4000_0000, base of the decoded region
SLAVE_ADDR_BITS, 12, log2 of each slave's window size; slave i occupies BASE_ADDR + i*2^SLAVE_ADDR_BITS
TIMEOUT_CYCLES, 16, max ACCESS cycles before forced termination; 0 disables the timeout

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset, asynchronous, active-low
req_valid  in  1  command valid
req_ready  out  1  command accepted when req_valid && req_ready at a PCLK rising edge
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_size  in  2  log2 bytes: 0=byte, 1=half, 2=word, 3=dword (64-bit only)
req_prot  in  3  protection attributes
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  set on PSLVERR, decode miss or timeout
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  NUM_SLAVES  one-hot select
PENABLE  out  1  access phase
PWRITE  out  1  direction
PWDATA  out  DATA_WIDTH  write data
PSTRB  out  STRB_WIDTH  write strobes
PPROT  out  3  protection
PREADY  in  NUM_SLAVES  per-slave ready
PRDATA  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (async, PRESETn low):
  - State=IDLE.
  - All outputs 0, except req_ready=1 once PRESETn is high.
  - A transfer in flight is abandoned immediately; no rsp_valid is produced for it.
- FSM states: IDLE, SETUP, ACCESS, DERR.
- All APB outputs and rsp_* are registered; req_ready is combinational.
- req_ready = (state==IDLE) || (state==ACCESS && PREADY[sel]).
- Decode:
  - off = req_addr - BASE_ADDR; idx = off >> SLAVE_ADDR_BITS.
  - Hit iff req_addr >= BASE_ADDR and idx < NUM_SLAVES.
  - idx is latched at acceptance.
- Accept with hit: next cycle is SETUP.
  - PSEL[idx]=1, PENABLE=0.
  - PADDR, PWRITE, PWDATA, PPROT, PSTRB loaded.
  - Following cycle is ACCESS with PENABLE=1; all other APB outputs held stable.
- Accept with miss: next cycle is DERR with no PSEL.
  - Following cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0; state returns to IDLE.
- ACCESS completion (PREADY[idx]=1 at an edge):
  - Next cycle: rsp_valid=1, rsp_err=PSLVERR[idx], rsp_rdata=PRDATA[idx] for reads (0 for writes or on error).
  - If a new command was accepted on the same edge: go to SETUP (PSEL re-driven, PENABLE=0). Otherwise go to IDLE (PSEL=0, PENABLE=0).
- PSLVERR and PRDATA are sampled only when PREADY[idx]=1.
- Timeout:
  - Counter clears on SETUP and increments each ACCESS cycle with PREADY low.
  - When it reaches TIMEOUT_CYCLES: next cycle PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; state returns to IDLE.
  - If PREADY rises on the timeout cycle, PREADY wins.
- PSTRB:
  - Reads drive 0.
  - Writes: nbytes = 1<<req_size; lane = req_addr[log2(STRB_WIDTH)-1:0] aligned down to nbytes; PSTRB = ((1<<nbytes)-1) << lane.
  - If nbytes >= STRB_WIDTH, PSTRB is all ones.
- PADDR is driven unmodified, including misaligned addresses; only PSTRB is aligned.
- Latency: minimum 3 cycles from acceptance to rsp_valid for a zero-wait-state slave; back-to-back throughput is 1 transfer per 2 cycles.

Test Plan:
1. Write 0xDEADBEEF, size 2, to 0x4000_2004, slave 2 PREADY immediate -> PSEL=4'b0100, PSTRB=4'b1111, PENABLE high exactly 1 cycle, rsp_valid with rsp_err=0 3 cycles after acceptance.
2. Byte write to 0x4000_1003; then half-word write to 0x4000_1003 -> PSTRB=4'b1000, then 4'b1100; PADDR=0x4000_1003 both times.
3. Read from slave 3 with PREADY low 5 cycles, PRDATA=0x12345678 -> PENABLE held 6 cycles, rsp_rdata=0x12345678, rsp_err=0.
4. Read from 0x4000_4000 (miss) -> PSEL stays 0, rsp_valid with rsp_err=1 and rsp_rdata=0 two cycles after acceptance; slave 1 holds PREADY low for 16 ACCESS cycles -> forced termination with rsp_err=1.
5. Two commands issued back-to-back (req_valid held) -> second SETUP directly follows first ACCESS completion (no IDLE cycle); PSLVERR=1 on the first yields rsp_err=1 for the first and 0 for the second.
6. Assert PRESETn low mid-ACCESS -> PSEL, PENABLE, rsp_valid go to 0 without waiting for PCLK; no response issued; after release, next command completes normally.
